// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for a 4-bit loadable up/down counter.
// The controller steers the counter's load/data/direction pins so that it
// sweeps between latched bounds, in either a sawtooth or a triangle pattern,
// for a programmable number of sweeps (0 = run until aborted).
// The counter has no enable, so "hold" is done by reloading its own value.
module counter_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int NW    = 4
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             mode,       // 0 = sawtooth, 1 = triangle
  input  logic [NW-1:0]    n_sweeps,   // 0 = continuous
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NW-1:0]    sweep_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN_UP = 3'd2,
    ST_RUN_DN = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             mode_q, mode_d;
  logic [NW-1:0]    n_q, n_d;
  logic [NW-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             complete_s;
  logic [NW-1:0]    sweep_inc_s;

  assign sweep_inc_s = sweep_cnt_q + NW'(1'b1);

  // Next-state, config latching and counter pin drive.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mode_d      = mode_q;
    n_d         = n_q;
    sweep_cnt_d = sweep_cnt_q;
    err_d       = 1'b0;
    complete_s  = 1'b0;
    // Hold: reload the counter with its own value.
    cnt_load    = 1'b1;
    cnt_d       = cnt_q;
    cnt_up      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi) begin
            err_d = 1'b1;
          end else begin
            lo_d        = lo;
            hi_d        = hi;
            mode_d      = mode;
            n_d         = n_sweeps;
            sweep_cnt_d = {NW{1'b0}};
            state_d     = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          cnt_d    = lo_q;
          cnt_up   = 1'b1;
          state_d  = ST_RUN_UP;
        end
      end

      ST_RUN_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == hi_q) begin
          if (mode_q && (lo_q != hi_q)) begin
            // Triangle turns around at the upper bound.
            cnt_load = 1'b0;
            cnt_up   = 1'b0;
            state_d  = ST_RUN_DN;
          end else begin
            // Sawtooth (or degenerate triangle) wraps back to the lower bound.
            complete_s = 1'b1;
            cnt_load   = 1'b1;
            cnt_d      = lo_q;
            cnt_up     = 1'b1;
          end
        end else begin
          // Anything other than the bound (including out-of-range values)
          // keeps counting up; modulo arithmetic brings it back.
          cnt_load = 1'b0;
          cnt_up   = 1'b1;
        end
      end

      ST_RUN_DN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == lo_q) begin
          complete_s = 1'b1;
          cnt_load   = 1'b0;
          cnt_up     = 1'b1;
          state_d    = ST_RUN_UP;
        end else begin
          cnt_load = 1'b0;
          cnt_up   = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A finished sweep bumps the counter; the last one freezes the counter.
    if (complete_s) begin
      sweep_cnt_d = sweep_inc_s;
      if ((n_q != {NW{1'b0}}) && (sweep_inc_s == n_q)) begin
        cnt_load = 1'b1;
        cnt_d    = cnt_q;
        cnt_up   = 1'b0;
        state_d  = ST_DONE;
      end else begin
        sweep_cnt_d = sweep_inc_s;
      end
    end else begin
      sweep_cnt_d = sweep_cnt_d;
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN_UP) || (state_d == ST_RUN_DN);
  end

  // State, latched configuration and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lo_q        <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      mode_q      <= 1'b0;
      n_q         <= {NW{1'b0}};
      sweep_cnt_q <= {NW{1'b0}};
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      sweep_cnt_q <= sweep_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a counter model is wired in closed loop and
// the observed counter value is compared against a trajectory built from the
// sweep rules (sawtooth / triangle ramps, sweep count, abort and done timing).
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, mode;
  logic [3:0] lo, hi, n_sweeps;
  logic       cnt_load, cnt_up, busy, done, err;
  logic [3:0] cnt_d, sweep_cnt;
  logic [3:0] plant_q;
  logic       force_en;
  logic [3:0] force_val;

  int tests_run = 0;
  int failed    = 0;
  int exp_q[$];
  bit exp_c[$];

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.WIDTH(4), .NW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .mode(mode), .n_sweeps(n_sweeps), .cnt_q(plant_q),
    .cnt_load(cnt_load), .cnt_d(cnt_d), .cnt_up(cnt_up),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  // The counter being controlled: load, else count up/down modulo 16.
  always @(posedge clk) begin
    if (force_en)      plant_q <= force_val;
    else if (cnt_load) plant_q <= cnt_d;
    else if (cnt_up)   plant_q <= plant_q + 4'd1;
    else               plant_q <= plant_q - 4'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected counter values in the RUN states, one per cycle, plus a flag
  // marking the cycles on which a sweep finishes.
  task automatic build_traj(input int l, input int h, input int m, input int sw);
    exp_q.delete();
    exp_c.delete();
    for (int s = 0; s < sw; s++) begin
      if (m == 0 || l == h) begin
        for (int v = l; v <= h; v++) begin
          exp_q.push_back(v);
          exp_c.push_back(v == h);
        end
      end else begin
        for (int v = (s == 0) ? l : l + 1; v <= h; v++) begin
          exp_q.push_back(v);
          exp_c.push_back(1'b0);
        end
        for (int v = h - 1; v >= l; v--) begin
          exp_q.push_back(v);
          exp_c.push_back(v == l);
        end
      end
    end
  endtask

  // Starts a sweep and follows it cycle by cycle; abort_k < 0 means no abort.
  task automatic drive_sweep(input int l, input int h, input int m, input int n,
                             input int sw, input int abort_k, input bit noise);
    int cnt;
    int last;
    lo = l[3:0]; hi = h[3:0]; mode = m[0]; n_sweeps = n[3:0];
    start = 1'b1;
    step();
    start = 1'b0;
    build_traj(l, h, m, (n == 0) ? sw : n);
    last = exp_q.size() - 1;
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL load_busy: got %0b want 1", busy); end
    tests_run++; if (sweep_cnt !== 4'd0) begin failed++; $display("FAIL load_clr: got %0d want 0", sweep_cnt); end
    cnt = 0;
    for (int k = 0; k <= last; k++) begin
      if (noise) begin
        lo = 4'($urandom); hi = 4'($urandom); mode = 1'($urandom);
        n_sweeps = 4'($urandom); start = 1'($urandom);
      end
      if (k == abort_k) abort = 1'b1;
      if (k > 0 && k != abort_k && exp_c[k-1]) cnt++;
      step();
      abort = 1'b0;
      if (k == abort_k) begin
        tests_run++; if (plant_q !== 4'(exp_q[k-1])) begin failed++; $display("FAIL abort_hold: got q=%0d want %0d", plant_q, exp_q[k-1]); end
        tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL abort_flags: got busy=%0b done=%0b want 0 0", busy, done); end
        tests_run++; if (sweep_cnt !== cnt[3:0]) begin failed++; $display("FAIL abort_cnt: got %0d want %0d", sweep_cnt, cnt[3:0]); end
        start = 1'b0;
        step();
        tests_run++; if (plant_q !== 4'(exp_q[k-1]) || busy !== 1'b0 || done !== 1'b0) begin
          failed++; $display("FAIL abort_after: got q=%0d busy=%0b done=%0b want q=%0d 0 0", plant_q, busy, done, exp_q[k-1]);
        end
        return;
      end
      tests_run++; if (plant_q !== 4'(exp_q[k]) || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        failed++; $display("FAIL run_k%0d: got q=%0d busy=%0b done=%0b err=%0b want q=%0d 1 0 0", k, plant_q, busy, done, err, exp_q[k]);
      end
      tests_run++; if (sweep_cnt !== cnt[3:0]) begin failed++; $display("FAIL run_cnt_k%0d: got %0d want %0d", k, sweep_cnt, cnt[3:0]); end
    end
    cnt++;
    step();
    tests_run++; if (plant_q !== 4'(exp_q[last]) || done !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL done_state: got q=%0d done=%0b busy=%0b want q=%0d 1 0", plant_q, done, busy, exp_q[last]);
    end
    tests_run++; if (sweep_cnt !== cnt[3:0]) begin failed++; $display("FAIL done_cnt: got %0d want %0d", sweep_cnt, cnt[3:0]); end
    start = 1'b0;
    step();
    tests_run++; if (plant_q !== 4'(exp_q[last]) || done !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL after_done: got q=%0d done=%0b busy=%0b want q=%0d 0 0", plant_q, done, busy, exp_q[last]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; force_en = 1'b1; force_val = 4'd7;
    step(); step();
    force_en = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++; if (cnt_load !== 1'b1 || cnt_d !== 4'd7) begin failed++; $display("FAIL reset_hold: got load=%0b d=%0d want 1 7", cnt_load, cnt_d); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failed++; $display("FAIL reset_flags: got busy=%0b done=%0b err=%0b want 0 0 0", busy, done, err); end
    tests_run++; if (sweep_cnt !== 4'd0) begin failed++; $display("FAIL reset_cnt: got %0d want 0", sweep_cnt); end
    step();
    tests_run++; if (plant_q !== 4'd7) begin failed++; $display("FAIL reset_q: got %0d want 7", plant_q); end
  endtask

  task automatic test_sawtooth();
    drive_sweep(3, 5, 0, 2, 0, -1, 1'b0);
  endtask

  task automatic test_triangle();
    drive_sweep(2, 4, 1, 1, 0, -1, 1'b0);
  endtask

  task automatic test_flat();
    drive_sweep(8, 8, 0, 3, 0, -1, 1'b0);
  endtask

  task automatic test_continuous_abort();
    int c;
    int j;
    build_traj(0, 15, 1, 18);
    c = 0;
    j = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (j < 0 && c >= 16 && exp_q[i] == 9) j = i;
      if (exp_c[i]) c++;
    end
    drive_sweep(0, 15, 1, 0, 18, j + 1, 1'b0);
  endtask

  task automatic test_reject();
    logic [3:0] held;
    held = plant_q;
    lo = 4'd6; hi = 4'd5; mode = 1'b0; n_sweeps = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++; if (err !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL reject_err: got err=%0b busy=%0b want 1 0", err, busy); end
    tests_run++; if (cnt_load !== 1'b1 || cnt_d !== held) begin failed++; $display("FAIL reject_hold: got load=%0b d=%0d want 1 %0d", cnt_load, cnt_d, held); end
    step();
    tests_run++; if (err !== 1'b0 || busy !== 1'b0 || plant_q !== held) begin
      failed++; $display("FAIL reject_after: got err=%0b busy=%0b q=%0d want 0 0 %0d", err, busy, plant_q, held);
    end
  endtask

  task automatic test_async_reset();
    lo = 4'd8; hi = 4'd8; mode = 1'b0; n_sweeps = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests_run++; if (sweep_cnt !== 4'd3 || busy !== 1'b1) begin failed++; $display("FAIL pre_reset: got cnt=%0d busy=%0b want 3 1", sweep_cnt, busy); end
    #3;
    reset = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || sweep_cnt !== 4'd0 || done !== 1'b0) begin
      failed++; $display("FAIL async_reset: got busy=%0b cnt=%0d done=%0b want 0 0 0", busy, sweep_cnt, done);
    end
    #1;
    reset = 1'b1;
    #1;
    tests_run++; if (cnt_load !== 1'b1 || cnt_d !== plant_q) begin failed++; $display("FAIL post_reset_hold: got load=%0b want 1", cnt_load); end
    step();
  endtask

  task automatic test_random();
    int l, h, m, n, len, ak;
    for (int it = 0; it < 8; it++) begin
      l = $urandom_range(0, 15);
      h = $urandom_range(l, 15);
      m = $urandom_range(0, 1);
      n = $urandom_range(1, 3);
      build_traj(l, h, m, n);
      len = exp_q.size();
      ak = -1;
      if (len > 1 && $urandom_range(0, 1) == 1) ak = $urandom_range(1, len - 1);
      drive_sweep(l, h, m, n, 0, ak, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    lo = 4'd0; hi = 4'd0; n_sweeps = 4'd0;
    force_en = 1'b1; force_val = 4'd7;
    test_reset();
    test_sawtooth();
    test_triangle();
    test_reject();
    test_flat();
    test_continuous_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the 4-bit loadable up/down counter. It drives the counter's load select, load data and direction pins so the counter sweeps between programmable bounds. It supports sawtooth and triangle patterns and a programmable sweep count. The controller sits beside the counter and observes the counter output `qout` (wired to `cnt_q`). Counter contract: on each clk edge, load=1 gives q<=D; otherwise up=1 increments and up=0 decrements, both modulo 2^WIDTH.

Parameters:
WIDTH, 4, counter and bound width
NW, 4, width of sweep-count request and sweep counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  start request, sampled only in IDLE
abort  in  1  stop sweep, hold counter value
lo  in  WIDTH  lower bound
hi  in  WIDTH  upper bound
mode  in  1  0=sawtooth, 1=triangle
n_sweeps  in  NW  sweeps to run; 0=continuous
cnt_q  in  WIDTH  counter output (qout)
cnt_load  out  1  to counter S
cnt_d  out  WIDTH  to counter D
cnt_up  out  1  to counter up_and_down; 1=count up
busy  out  1  high in LOAD/RUN_UP/RUN_DN
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse when start is rejected
sweep_cnt  out  NW  completed sweeps, wraps modulo 2^NW

Behaviour:
- Reset:
  - While reset=0: state=IDLE; lo_r, hi_r, mode_r, n_r, sweep_cnt, err = 0.
  - done=0, busy=0.
- Registers vs combinational:
  - State, latched config, sweep_cnt, err and done are registered.
  - cnt_load, cnt_d and cnt_up are combinational from state, latched config and cnt_q. This lets the counter turn exactly at a bound.
- Hold action (HOLD): cnt_load=1, cnt_d=cnt_q, cnt_up=0. The counter has no enable, so the controller freezes it by reloading its own value.
- IDLE:
  - Outputs use HOLD.
  - On start=1 with lo>hi: err=1 for the next cycle; stay in IDLE.
  - On start=1 otherwise: latch lo/hi/mode/n_sweeps; clear sweep_cnt; go to LOAD.
- LOAD: cnt_load=1, cnt_d=lo_r, cnt_up=1; next state RUN_UP. After this edge, q=lo.
- RUN_UP:
  - cnt_q<hi_r: cnt_load=0, cnt_up=1.
  - cnt_q==hi_r, sawtooth, or triangle with lo_r==hi_r: sweep completes. Drive cnt_load=1, cnt_d=lo_r; stay in RUN_UP.
  - cnt_q==hi_r, triangle with lo_r<hi_r: cnt_load=0, cnt_up=0; go to RUN_DN.
- RUN_DN:
  - cnt_q>lo_r: cnt_load=0, cnt_up=0.
  - cnt_q==lo_r: sweep completes. Drive cnt_load=0, cnt_up=1; go to RUN_UP.
- Sweep completion:
  - sweep_cnt increments.
  - If n_r!=0 and sweep_cnt+1==n_r: override the outputs with HOLD and go to DONE.
- DONE: HOLD; done=1 during this state (single cycle); busy=0; next state IDLE.
- abort=1 in LOAD/RUN_UP/RUN_DN: HOLD that cycle; go to IDLE. No done; sweep_cnt keeps its value. abort beats sweep completion and final-sweep detection.
- start while busy or in DONE is ignored. abort in IDLE/DONE has no effect.
- Out-of-range cnt_q in RUN states is recovered naturally by the counter's modulo arithmetic; no extra check.
- Async reset mid-sweep returns to IDLE immediately. After release, outputs use HOLD.

Test Plan:
- Reset then idle, cnt_q=4'h7: cnt_load=1, cnt_d=7, busy=0, done=0, sweep_cnt=0.
- Sawtooth, lo=3, hi=5, n=2:
  - q sequence after LOAD is 3,4,5,3,4,5, then holds at 5.
  - done pulses once; sweep_cnt=2; busy falls together with done.
- Triangle, lo=2, hi=4, n=1: q=2,3,4,3,2, then holds at 2; done pulses once; sweep_cnt=1.
- Triangle, lo=0, hi=15, n=0 (continuous):
  - Repeats 0..15..0; sweep_cnt wraps 15->0 after 16 sweeps.
  - abort at q=9: q stays 9, busy=0 next cycle, done never pulses.
- start with lo=6, hi=5: err=1 for exactly one cycle; busy stays 0; counter held.
- Sawtooth, lo=hi=8, n=3: q=8 each cycle; sweep_cnt 1,2,3; done after 3 cycles in RUN_UP.
- reset=0 asserted mid-RUN_UP, with no clock edge needed: busy=0, sweep_cnt=0 immediately.
